// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with next-PC selection and a circular return-address stack.
// Exception beats stall; otherwise branch > return > jump/call > sequential when enabled.
module program_counter_ras #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       INC        = 4,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
  parameter logic [31:0]       EXC_VECTOR = 32'h80,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             PC_en,
  input  logic             Exc,
  input  logic             Branch_taken,
  input  logic [WIDTH-1:0] Branch_target,
  input  logic             Jump,
  input  logic             Call,
  input  logic [WIDTH-1:0] Jump_target,
  input  logic             Ret,
  input  logic [WIDTH-1:0] Ret_fallback,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus,
  output logic             Ras_empty,
  output logic             Ras_full,
  output logic             Ras_ovf,
  output logic             Ras_unf
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty_q, full_q;
  logic             push;
  logic [WIDTH-1:0] pc_plus;

  assign pc_plus = pc_q + WIDTH'(INC);

  // Next-PC selection and stack pointer bookkeeping
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (Exc) begin
      pc_d    = WIDTH'(EXC_VECTOR);
      count_d = '0;
    end else if (PC_en) begin
      if (Branch_taken) begin
        pc_d = Branch_target;
      end else if (Ret) begin
        if (count_q != '0) begin
          pc_d    = ras_q[top_q];
          top_d   = top_q - PW'(1);
          count_d = count_q - CW'(1);
        end else begin
          pc_d  = Ret_fallback;
          unf_d = 1'b1;
        end
      end else if (Jump) begin
        pc_d = Jump_target;
        if (Call) begin
          push  = 1'b1;
          top_d = top_q + PW'(1);
          // A full stack wraps onto its oldest entry
          if (count_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
          else                           count_d = count_q + CW'(1);
        end
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q    <= RESET_ADDR;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(RAS_DEPTH));
      if (push) ras_q[top_q + PW'(1)] <= pc_plus;
    end
  end

  assign PCResult  = pc_q;
  assign PCPlus    = pc_plus;
  assign Ras_empty = empty_q;
  assign Ras_full  = full_q;
  assign Ras_ovf   = ovf_q;
  assign Ras_unf   = unf_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Bench for program_counter_ras: directed scenarios plus random traffic against a queue-based model.
module tb_program_counter_ras;

  logic        Clk, Reset_n;
  logic        PC_en, Exc, Branch_taken, Jump, Call, Ret;
  logic [31:0] Branch_target, Jump_target, Ret_fallback;
  logic [31:0] PCResult, PCPlus;
  logic        Ras_empty, Ras_full, Ras_ovf, Ras_unf;

  logic       b_br;
  logic [7:0] b_bt, b_zero8, b_pc, b_plus;
  logic       b_empty, b_full, b_ovf, b_unf;

  int errors = 0;
  int checks = 0;

  // Reference model: plain PC plus a bounded queue of return addresses
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;

  program_counter_ras dut (
    .Clk(Clk), .Reset_n(Reset_n), .PC_en(PC_en), .Exc(Exc),
    .Branch_taken(Branch_taken), .Branch_target(Branch_target),
    .Jump(Jump), .Call(Call), .Jump_target(Jump_target),
    .Ret(Ret), .Ret_fallback(Ret_fallback),
    .PCResult(PCResult), .PCPlus(PCPlus),
    .Ras_empty(Ras_empty), .Ras_full(Ras_full), .Ras_ovf(Ras_ovf), .Ras_unf(Ras_unf)
  );

  program_counter_ras #(.WIDTH(8), .INC(4), .RESET_ADDR(8'h00), .EXC_VECTOR(32'h80), .RAS_DEPTH(4)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .PC_en(1'b1), .Exc(1'b0),
    .Branch_taken(b_br), .Branch_target(b_bt),
    .Jump(1'b0), .Call(1'b0), .Jump_target(b_zero8),
    .Ret(1'b0), .Ret_fallback(b_zero8),
    .PCResult(b_pc), .PCPlus(b_plus),
    .Ras_empty(b_empty), .Ras_full(b_full), .Ras_ovf(b_ovf), .Ras_unf(b_unf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step();
    logic [31:0] seq;
    logic [31:0] dropped;
    seq = m_pc + 32'd4;
    if (Exc) begin
      m_pc = 32'h80;
      m_ras.delete();
    end else if (PC_en) begin
      if (Branch_taken) m_pc = Branch_target;
      else if (Ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc  = Ret_fallback;
          m_unf = 1'b1;
        end
      end else if (Jump) begin
        if (Call) begin
          m_ras.push_back(seq);
          if (m_ras.size() > 4) begin
            dropped = m_ras.pop_front();
            m_ovf   = 1'b1;
          end
        end
        m_pc = Jump_target;
      end else m_pc = seq;
    end
  endfunction

  task automatic idle();
    PC_en = 1'b1; Exc = 1'b0; Branch_taken = 1'b0; Jump = 1'b0; Call = 1'b0; Ret = 1'b0;
    Branch_target = '0; Jump_target = '0; Ret_fallback = '0;
  endtask

  task automatic cyc();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle(); Branch_taken = 1'b1; Branch_target = addr; cyc(); idle();
  endtask

  task automatic test_reset();
    idle(); b_br = 1'b0; b_bt = '0; b_zero8 = '0;
    Reset_n = 1'b0;
    model_reset();
    #12;
    checks++; if (PCResult !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", PCResult); end
    checks++; if ({Ras_empty, Ras_full, Ras_ovf, Ras_unf} !== 4'b1000) begin errors++;
      $display("FAIL reset_flags: got %b want 1000", {Ras_empty, Ras_full, Ras_ovf, Ras_unf}); end
    #1 Reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++; if (PCResult !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, PCResult, 32'(i * 4)); end
    end
    checks++; if ({Ras_empty, Ras_ovf, Ras_unf} !== 3'b100) begin errors++;
      $display("FAIL seq_flags: got %b want 100", {Ras_empty, Ras_ovf, Ras_unf}); end
  endtask

  task automatic test_stall();
    go_to(32'h10);
    PC_en = 1'b0; Branch_taken = 1'b1; Branch_target = 32'h400; cyc();
    checks++; if (PCResult !== 32'h10) begin errors++; $display("FAIL stall_hold: got %h want 10", PCResult); end
    Exc = 1'b1; cyc(); idle();
    checks++; if (PCResult !== 32'h80) begin errors++; $display("FAIL stall_exc: got %h want 80", PCResult); end
  endtask

  task automatic test_call_ret();
    go_to(32'h100);
    Jump = 1'b1; Call = 1'b1; Jump_target = 32'h200; cyc(); idle();
    checks++; if (PCResult !== 32'h200 || Ras_empty !== 1'b0) begin errors++;
      $display("FAIL call_pc: got %h empty=%b want 200 empty=0", PCResult, Ras_empty); end
    cyc(); cyc();
    checks++; if (PCResult !== 32'h208 || PCPlus !== 32'h20C) begin errors++;
      $display("FAIL call_seq: got %h/%h want 208/20c", PCResult, PCPlus); end
    Ret = 1'b1; cyc(); idle();
    checks++; if (PCResult !== 32'h104 || Ras_empty !== 1'b1) begin errors++;
      $display("FAIL ret_pc: got %h empty=%b want 104 empty=1", PCResult, Ras_empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14};
    go_to(32'h0);
    for (int i = 0; i < 5; i++) begin
      Jump = 1'b1; Call = 1'b1; Jump_target = 32'((i + 1) * 16); cyc(); idle();
    end
    checks++; if (Ras_ovf !== 1'b1 || Ras_full !== 1'b1) begin errors++;
      $display("FAIL ovf_flags: got ovf=%b full=%b want 1 1", Ras_ovf, Ras_full); end
    for (int i = 0; i < 4; i++) begin
      Ret = 1'b1; cyc(); idle();
      checks++; if (PCResult !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d: got %h want %h", i, PCResult, exp_ret[i]); end
    end
    checks++; if (Ras_unf !== 1'b0 || Ras_empty !== 1'b1) begin errors++;
      $display("FAIL drained: got unf=%b empty=%b want 0 1", Ras_unf, Ras_empty); end
    Ret = 1'b1; Ret_fallback = 32'h999; cyc(); idle();
    checks++; if (PCResult !== 32'h999 || Ras_unf !== 1'b1) begin errors++;
      $display("FAIL unf_ret: got %h unf=%b want 999 1", PCResult, Ras_unf); end
  endtask

  task automatic test_priority();
    Jump = 1'b1; Call = 1'b1; Jump_target = 32'h500; cyc(); idle();
    Branch_taken = 1'b1; Branch_target = 32'h300; Ret = 1'b1; Jump = 1'b1; Call = 1'b1;
    Jump_target = 32'h600; cyc(); idle();
    checks++; if (PCResult !== 32'h300 || Ras_empty !== 1'b0 || Ras_full !== 1'b0) begin errors++;
      $display("FAIL prio_pc: got %h empty=%b full=%b want 300 0 0", PCResult, Ras_empty, Ras_full); end
    Ret = 1'b1; cyc(); idle();
    checks++; if (PCResult !== 32'h99D || Ras_empty !== 1'b1) begin errors++;
      $display("FAIL prio_ret: got %h empty=%b want 99d 1", PCResult, Ras_empty); end
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFFC);
    checks++; if (PCPlus !== 32'h0) begin errors++; $display("FAIL wrap_plus: got %h want 0", PCPlus); end
    b_br = 1'b1; b_bt = 8'hFC; cyc(); b_br = 1'b0;
    checks++; if (PCResult !== 32'h0) begin errors++; $display("FAIL wrap32: got %h want 0", PCResult); end
    checks++; if (b_pc !== 8'hFC || b_plus !== 8'h00) begin errors++; $display("FAIL wrap8_at: got %h/%h want fc/00", b_pc, b_plus); end
    cyc();
    checks++; if (b_pc !== 8'h00) begin errors++; $display("FAIL wrap8: got %h want 00", b_pc); end
  endtask

  task automatic test_reset_mid();
    go_to(32'h40);
    Jump = 1'b1; Call = 1'b1; Jump_target = 32'h700; cyc();
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (PCResult !== 32'h0 || {Ras_empty, Ras_ovf, Ras_unf} !== 3'b100) begin errors++;
      $display("FAIL mid_reset: got %h flags=%b want 0 100", PCResult, {Ras_empty, Ras_ovf, Ras_unf}); end
    @(posedge Clk); #1;
    checks++; if (PCResult !== 32'h0 || Ras_empty !== 1'b1) begin errors++;
      $display("FAIL reset_hold: got %h empty=%b want 0 1", PCResult, Ras_empty); end
    #2 Reset_n = 1'b1;
    model_reset();
    idle();
    Ret = 1'b1; Ret_fallback = 32'h123; cyc(); idle();
    checks++; if (PCResult !== 32'h123 || Ras_unf !== 1'b1) begin errors++;
      $display("FAIL post_reset_ret: got %h unf=%b want 123 1", PCResult, Ras_unf); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      PC_en         = ($urandom_range(7) != 0);
      Exc           = ($urandom_range(31) == 0);
      Branch_taken  = ($urandom_range(5) == 0);
      Ret           = ($urandom_range(3) == 0);
      Jump          = ($urandom_range(2) == 0);
      Call          = 1'($urandom_range(1));
      Branch_target = $urandom() & 32'hFFFF_FFFC;
      Jump_target   = $urandom() & 32'hFFFF_FFFC;
      Ret_fallback  = $urandom() & 32'hFFFF_FFFC;
      cyc();
      checks++;
      if (PCResult !== m_pc || PCPlus !== m_pc + 32'd4 || Ras_empty !== (m_ras.size() == 0) ||
          Ras_full !== (m_ras.size() == 4) || Ras_ovf !== m_ovf || Ras_unf !== m_unf) begin
        errors++;
        $display("FAIL rand%0d: got pc=%h e=%b f=%b o=%b u=%b want pc=%h e=%b f=%b o=%b u=%b", n,
                 PCResult, Ras_empty, Ras_full, Ras_ovf, Ras_unf,
                 m_pc, (m_ras.size() == 0), (m_ras.size() == 4), m_ovf, m_unf);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_call_ret();
    test_overflow();
    test_priority();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
